pc_fetch: RTL and testbench
===========================

// Module: pc_fetch
// PURPOSE
//  Program counter and instruction fetch stage, directly upstream of the control decoder.
//  Holds PC and fetches the instruction word from instruction memory over a req/ack handshake.
//  Latches the word into the instruction register and presents OpCode/Imm to control and datapath.
//  Consumes control's PcSel (PcWait/PcInc/PcJmp) and the ALU result as jump target to advance PC.
// PARAMETERS
//  PC_W        8          PC / instruction address width
//  INSTR_W     16         instruction word width
//  IMM_W       8          immediate field width, Instr[IMM_W-1:0]
//  RESET_VEC   0          PC value loaded at reset
// PORTS
//  Clock       in   1        rising-edge clock
//  nReset      in   1        asynchronous, active-low reset
//  PcSel       in   PcSel_t  opcodes::PcSel_t from control: PcWait, PcInc, PcJmp
//  JumpAddr    in   INSTR_W  ALU result; jump target when PcSel==PcJmp
//  ImemAddr    out  PC_W     instruction memory address (=PC)
//  ImemReq     out  1        fetch request, held until ack
//  ImemAck     in   1        memory ack; ImemRData valid in the same cycle
//  ImemRData   in   INSTR_W  instruction read data
//  OpCode      out  opcodes_t  Instr[INSTR_W-1 -: $bits(opcodes_t)]
//  Imm         out  IMM_W    Instr[IMM_W-1:0]
//  InstrValid  out  1        instruction register holds a fetched, unexecuted word
//  Pc          out  PC_W     current PC (JMPI operand)
// BEHAVIOUR
//  Reset (nReset=0, async): PC=RESET_VEC, IR=0 (OpCode=NOOP), InstrValid=0, ImemReq=0, state=RESET_WAIT.
//  FSM states: RESET_WAIT -> REQ -> HOLD -> REQ ...
//   RESET_WAIT: one cycle after reset release, ImemReq=0; then -> REQ.
//   REQ: ImemReq=1, ImemAddr=PC stable. On ImemAck: IR<=ImemRData, InstrValid<=1, -> HOLD.
//        Without ack: stay in REQ indefinitely, req/addr held. PcSel ignored.
//   HOLD: ImemReq=0, InstrValid=1, IR stable. PcSel sampled every clock:
//        PcWait: PC, IR unchanged, stay HOLD (no refetch; WAIT0/WAIT1 spin here).
//        PcInc : PC<=PC+1 mod 2^PC_W (PC=all-ones wraps to 0); InstrValid<=0; -> REQ.
//        PcJmp : PC<=JumpAddr[PC_W-1:0] (upper bits discarded); InstrValid<=0; -> REQ.
//        Illegal PcSel encoding: treated as PcWait.
//  Latency: ack cycle -> InstrValid=1 next edge; PcInc/PcJmp edge -> ImemReq=1 same edge's output,
//   minimum 2 clocks between successive InstrValid rises with zero-wait memory.
//  ImemAck outside REQ ignored (no IR update, no state change).
//  OpCode/Imm driven from IR only (registered); never combinationally from ImemRData.
//  While InstrValid=0, OpCode still reflects old IR; control must be gated on InstrValid.
//  Reset mid-fetch: request dropped immediately (async), fetch restarts from RESET_VEC.
//  Pc output changes only on PcInc/PcJmp in HOLD or at reset.
// TESTING
//  Reset release, mem acks in 1 cycle with 0x1234 @0 -> ImemReq at addr 0, IR=0x1234, InstrValid=1, Pc=0.
//  HOLD with PcSel=PcWait for 5 clocks -> PC, IR, InstrValid unchanged, ImemReq=0 throughout.
//  PC=0xFF (PC_W=8), PcSel=PcInc -> PC=0x00, ImemAddr=0x00, ImemReq=1 next cycle.
//  PcSel=PcJmp, JumpAddr=0x1A37 -> PC=0x37, fetch at 0x37, InstrValid=0 until ack.
//  Ack delayed 4 cycles; PcSel toggled PcInc/PcJmp during REQ -> ignored, addr stable, PC unchanged.
//  nReset asserted mid-REQ then ack arrives after release -> ImemReq=0 during reset, PC=RESET_VEC, stray ack in RESET_WAIT ignored.

Source files
------------

// File: rtl/pc_fetch.sv
// Program counter and instruction fetch stage: holds PC, fetches over a req/ack
// handshake into the instruction register and presents OpCode/Imm downstream.

package opcodes;
   typedef enum logic [3:0] {
      NOOP  = 4'h0,
      LDI   = 4'h1,
      ADD   = 4'h2,
      SUB   = 4'h3,
      AND   = 4'h4,
      OR    = 4'h5,
      XOR   = 4'h6,
      LD    = 4'h7,
      ST    = 4'h8,
      JMP   = 4'h9,
      JMPI  = 4'hA,
      JZ    = 4'hB,
      WAIT0 = 4'hC,
      WAIT1 = 4'hD,
      OUT   = 4'hE,
      HALT  = 4'hF
   } opcodes_t;

   typedef enum logic [1:0] {
      PcWait = 2'b00,
      PcInc  = 2'b01,
      PcJmp  = 2'b10
   } PcSel_t;
endpackage

// state      | meaning
// RESET_WAIT | one idle cycle after reset release, no request
// REQ        | ImemReq high at ImemAddr=PC until ImemAck loads IR
// HOLD       | IR valid, PcSel decides wait / increment / jump
module pc_fetch
   import opcodes::*;
#(
   parameter int              PC_W      = 8,
   parameter int              INSTR_W   = 16,
   parameter int              IMM_W     = 8,
   parameter logic [PC_W-1:0] RESET_VEC = '0
) (
   input  logic               Clock,
   input  logic               nReset,
   input  PcSel_t             PcSel,
   input  logic [INSTR_W-1:0] JumpAddr,
   output logic [PC_W-1:0]    ImemAddr,
   output logic               ImemReq,
   input  logic               ImemAck,
   input  logic [INSTR_W-1:0] ImemRData,
   output opcodes_t           OpCode,
   output logic [IMM_W-1:0]   Imm,
   output logic               InstrValid,
   output logic [PC_W-1:0]    Pc
);

   typedef enum logic [1:0] {
      RESET_WAIT = 2'b00,
      REQ        = 2'b01,
      HOLD       = 2'b10
   } fetchState_t;

   fetchState_t        state;
   fetchState_t        stateNext;
   logic [PC_W-1:0]    pcReg;
   logic [PC_W-1:0]    pcNext;
   logic [INSTR_W-1:0] instrReg;
   logic               irLoad;
   logic               validReg;
   logic               validNext;
   logic               unusedBits;

   always_ff @(posedge Clock or negedge nReset) begin
      if (!nReset) begin
         state    <= RESET_WAIT;
         pcReg    <= RESET_VEC;
         instrReg <= '0;
         validReg <= 1'b0;
      end else begin
         state    <= stateNext;
         pcReg    <= pcNext;
         validReg <= validNext;
         if (irLoad) begin
            instrReg <= ImemRData;
         end
      end
   end

   // Acks are only honoured in REQ; PcSel is only honoured in HOLD.
   always_comb begin
      stateNext = state;
      pcNext    = pcReg;
      validNext = validReg;
      irLoad    = 1'b0;
      case (state)
         RESET_WAIT: begin
            stateNext = REQ;
         end
         REQ: begin
            if (ImemAck) begin
               irLoad    = 1'b1;
               validNext = 1'b1;
               stateNext = HOLD;
            end
         end
         HOLD: begin
            case (PcSel)
               PcInc: begin
                  pcNext    = pcReg + PC_W'(1);
                  validNext = 1'b0;
                  stateNext = REQ;
               end
               PcJmp: begin
                  pcNext    = JumpAddr[PC_W-1:0];
                  validNext = 1'b0;
                  stateNext = REQ;
               end
               default: begin
               end
            endcase
         end
         default: begin
            stateNext = RESET_WAIT;
         end
      endcase
   end

   assign ImemReq    = (state == REQ);
   assign ImemAddr   = pcReg;
   assign Pc         = pcReg;
   assign InstrValid = validReg;
   assign OpCode     = opcodes_t'(instrReg[INSTR_W-1 -: $bits(opcodes_t)]);
   assign Imm        = instrReg[IMM_W-1:0];

   assign unusedBits = ^{JumpAddr, instrReg};

endmodule

// File: tb/tb_pc_fetch.sv
// Self-checking bench for pc_fetch: a memory responder with programmable ack delay,
// a vector table of PC-select steps and a scoreboard of expected fetches.
module tb_pc_fetch;
   import opcodes::*;

   localparam int PC_W    = 8;
   localparam int INSTR_W = 16;
   localparam int IMM_W   = 8;

   logic               Clock = 1'b0;
   logic               nReset = 1'b0;
   logic [1:0]         PcSelRaw;
   logic [INSTR_W-1:0] JumpAddr;
   logic [PC_W-1:0]    ImemAddr;
   logic               ImemReq;
   logic               ImemAck;
   logic [INSTR_W-1:0] ImemRData;
   opcodes_t           OpCode;
   logic [IMM_W-1:0]   Imm;
   logic               InstrValid;
   logic [PC_W-1:0]    Pc;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [PC_W-1:0]    pc;
      logic [INSTR_W-1:0] word;
   } exp_t;
   exp_t sbQ[$];

   typedef struct {
      logic [1:0]         sel;
      logic [INSTR_W-1:0] jump;
      int                 ackDelay;
      bit                 toggle;
      logic [PC_W-1:0]    expPc;
   } vec_t;
   vec_t vecs[10];

   pc_fetch #(.PC_W(PC_W), .INSTR_W(INSTR_W), .IMM_W(IMM_W), .RESET_VEC(8'h00)) dut (
      .Clock      (Clock),
      .nReset     (nReset),
      .PcSel      (PcSel_t'(PcSelRaw)),
      .JumpAddr   (JumpAddr),
      .ImemAddr   (ImemAddr),
      .ImemReq    (ImemReq),
      .ImemAck    (ImemAck),
      .ImemRData  (ImemRData),
      .OpCode     (OpCode),
      .Imm        (Imm),
      .InstrValid (InstrValid),
      .Pc         (Pc)
   );

   always #5 Clock = ~Clock;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
      $fatal(1, "watchdog");
   end

   function automatic logic [INSTR_W-1:0] memWord(input logic [PC_W-1:0] a);
      if (a == 8'h00) return 16'h1234;
      return {a ^ 8'hA5, a};
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Serves one fetch from the scoreboard head: waits for the request, optionally
   // stalls with PcSel toggling, then acks and checks the latched instruction.
   task automatic fetchAndCheck(input int delay, input bit toggle, input string name);
      exp_t e;
      int   n = 0;
      while (ImemReq !== 1'b1 && n < 20) begin
         @(negedge Clock);
         n++;
      end
      check({name, "_req_seen"}, 32'(ImemReq), 32'd1);
      if (sbQ.size() == 0) begin
         check({name, "_sb_empty"}, 32'd0, 32'd1);
         return;
      end
      e = sbQ.pop_front();
      check({name, "_addr"}, {ImemAddr, Pc, 7'd0, InstrValid, 8'd0}, {e.pc, e.pc, 16'd0});
      for (int i = 0; i < delay; i++) begin
         if (toggle) begin
            PcSelRaw = (i % 2 == 0) ? 2'b01 : 2'b10;
            JumpAddr = 16'($urandom);
         end
         ImemAck = 1'b0;
         @(negedge Clock);
         check({name, "_stall"}, {7'd0, ImemReq, 7'd0, InstrValid, ImemAddr, Pc},
               {8'd1, 8'd0, e.pc, e.pc});
      end
      PcSelRaw  = 2'b00;
      ImemAck   = 1'b1;
      ImemRData = e.word;
      @(negedge Clock);
      ImemAck   = 1'b0;
      ImemRData = 16'hDEAD;
      check({name, "_ir"}, {4'd0, 4'(OpCode), Imm, 7'd0, InstrValid, 7'd0, ImemReq},
            {4'd0, e.word[15:12], e.word[7:0], 8'd1, 8'd0});
      check({name, "_pc"}, 32'(Pc), 32'(e.pc));
   endtask

   initial begin
      vecs[0] = '{2'b01, 16'h0000, 0, 1'b0, 8'h01};
      vecs[1] = '{2'b10, 16'h1A37, 0, 1'b0, 8'h37};
      vecs[2] = '{2'b01, 16'h0000, 2, 1'b0, 8'h38};
      vecs[3] = '{2'b10, 16'h00FE, 1, 1'b0, 8'hFE};
      vecs[4] = '{2'b01, 16'h0000, 0, 1'b0, 8'hFF};
      vecs[5] = '{2'b01, 16'h0000, 0, 1'b0, 8'h00};
      vecs[6] = '{2'b10, 16'hFF80, 4, 1'b1, 8'h80};
      vecs[7] = '{2'b11, 16'h1234, 0, 1'b0, 8'h80};
      vecs[8] = '{2'b00, 16'h5555, 0, 1'b0, 8'h80};
      vecs[9] = '{2'b01, 16'h0000, 3, 1'b1, 8'h81};

      PcSelRaw  = 2'b00;
      JumpAddr  = '0;
      ImemAck   = 1'b0;
      ImemRData = '0;
      nReset    = 1'b0;
      repeat (2) @(negedge Clock);
      check("reset_state", {7'd0, ImemReq, 7'd0, InstrValid, Pc, 4'd0, 4'(OpCode)},
            {8'd0, 8'd0, 8'h00, 8'h00});

      nReset = 1'b1;
      #1;
      check("reset_wait_noreq", 32'(ImemReq), 32'd0);
      sbQ.push_back('{8'h00, memWord(8'h00)});
      fetchAndCheck(0, 1'b0, "first");

      for (int i = 0; i < 5; i++) begin
         PcSelRaw = 2'b00;
         @(negedge Clock);
         check("hold_wait", {Pc, 7'd0, InstrValid, 7'd0, ImemReq, 4'(OpCode), 4'd0},
               {8'h00, 8'd1, 8'd0, 8'h10});
         check("hold_wait_imm", 32'(Imm), 32'h34);
      end

      ImemAck   = 1'b1;
      ImemRData = 16'hFFFF;
      @(negedge Clock);
      ImemAck   = 1'b0;
      check("stray_ack_hold", {4'd0, 4'(OpCode), Imm, 7'd0, InstrValid, 7'd0, ImemReq},
            {8'h01, 8'h34, 8'd1, 8'd0});

      foreach (vecs[k]) begin
         PcSelRaw = vecs[k].sel;
         JumpAddr = vecs[k].jump;
         @(negedge Clock);
         PcSelRaw = 2'b00;
         if (vecs[k].sel == 2'b01 || vecs[k].sel == 2'b10) begin
            check($sformatf("vec%0d_step", k), {7'd0, ImemReq, 7'd0, InstrValid, ImemAddr, Pc},
                  {8'd1, 8'd0, vecs[k].expPc, vecs[k].expPc});
            sbQ.push_back('{vecs[k].expPc, memWord(vecs[k].expPc)});
            fetchAndCheck(vecs[k].ackDelay, vecs[k].toggle, $sformatf("vec%0d", k));
         end else begin
            check($sformatf("vec%0d_wait", k), {7'd0, ImemReq, 7'd0, InstrValid, 8'd0, Pc},
                  {8'd0, 8'd1, 8'd0, vecs[k].expPc});
         end
      end

      PcSelRaw = 2'b01;
      @(negedge Clock);
      PcSelRaw = 2'b00;
      check("pre_reset_req", {7'd0, ImemReq, 8'd0, 8'd0, Pc}, {8'd1, 8'd0, 8'd0, 8'h82});
      nReset = 1'b0;
      #1;
      check("mid_reset", {7'd0, ImemReq, 7'd0, InstrValid, Pc, 4'd0, 4'(OpCode)},
            {8'd0, 8'd0, 8'h00, 8'h00});
      ImemAck   = 1'b1;
      ImemRData = 16'hBEEF;
      @(negedge Clock);
      nReset = 1'b1;
      @(negedge Clock);
      check("after_reset_stray_ack", {7'd0, ImemReq, 7'd0, InstrValid, Pc, 4'(OpCode), 4'd0},
            {8'd1, 8'd0, 8'h00, 8'h00});
      check("after_reset_imm", 32'(Imm), 32'd0);
      ImemAck   = 1'b0;
      ImemRData = 16'h0000;
      sbQ.push_back('{8'h00, memWord(8'h00)});
      fetchAndCheck(1, 1'b0, "refetch");

      check("sb_drained", 32'(sbQ.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
